// File: rtl/alarm_unit.sv
// alarm_unit: programmable alarm stage behind the 12-hour BCD clock counter.
// Stores an alarm time, compares it against the running clock on each 1 Hz
// tick and drives the buzzer through a four-state FSM. The FSM supports
// snooze, stop and auto-timeout.
//
// Ports:
//   clk, reset (synchronous, active-low)
//   ena            1 Hz tick, one cycle wide
//   hh/mm/ss/pm    current time (BCD) and AM/PM
//   arm            alarm enable switch (level)
//   set_alarm      load pulse for set_hh/set_mm/set_pm
//   snooze, stop   user pulses
//   alarm_hh/mm/pm stored alarm time
//   ring           buzzer drive
//   state          00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE
//   snooze_left    remaining snoozes for the current alarm event
//   set_err        one-cycle pulse when a set_alarm is rejected
//
// Optional feature: define ALARM_BEEP_EN to make ring toggle on each ena
// while RINGING, giving a 1 s on / 1 s off pattern. Without it, ring is
// held high for the whole RINGING period.
module alarm_unit #(
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       pm,
    input  logic       arm,
    input  logic       set_alarm,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic       set_pm,
    input  logic       snooze,
    input  logic       stop,
    output logic [7:0] alarm_hh,
    output logic [7:0] alarm_mm,
    output logic       alarm_pm,
    output logic       ring,
    output logic [1:0] state,
    output logic [2:0] snooze_left,
    output logic       set_err
);

    localparam int unsigned CW = 9;

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_ARMED   = 2'b01;
    localparam logic [1:0] S_RINGING = 2'b10;
    localparam logic [1:0] S_SNOOZE  = 2'b11;

    localparam logic [CW-1:0] RING_LIM = CW'(RING_SEC);
    localparam logic [CW-1:0] SNZ_LIM  = CW'(SNOOZE_SEC);
    localparam logic [2:0]    SNZ_MAX  = 3'(MAX_SNOOZE);

    logic [1:0]    state_d;
    logic [CW-1:0] ring_cnt, ring_cnt_d, ring_cnt_inc;
    logic [CW-1:0] snz_cnt, snz_cnt_d, snz_cnt_inc;
    logic [2:0]    left_d;
    logic          ring_d;
    logic          set_ok;
    logic          match;

    // Hour must be BCD 01..12, minute BCD 00..59, every nibble a decimal digit.
    function automatic logic hour_ok(input logic [7:0] v);
        return (v[7:4] == 4'd0 && v[3:0] >= 4'd1 && v[3:0] <= 4'd9) ||
               (v[7:4] == 4'd1 && v[3:0] <= 4'd2);
    endfunction

    function automatic logic minute_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    assign set_ok = hour_ok(set_hh) && minute_ok(set_mm);

    // Match fires only at second zero of the alarm minute, on the tick.
    assign match = ena && (hh == alarm_hh) && (mm == alarm_mm) &&
                   (pm == alarm_pm) && (ss == 8'h00);

    // Saturating increments: counters never wrap.
    assign ring_cnt_inc = (ring_cnt == '1) ? ring_cnt : ring_cnt + CW'(1);
    assign snz_cnt_inc  = (snz_cnt == '1)  ? snz_cnt  : snz_cnt + CW'(1);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        ring_cnt_d = ring_cnt;
        snz_cnt_d  = snz_cnt;
        left_d     = snooze_left;
        ring_d     = 1'b0;

        case (state)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (match) begin
                    state_d    = S_RINGING;
                    ring_cnt_d = '0;
                end
            end
            S_RINGING: begin
                // A snooze with none left behaves as stop.
                if (stop || (snooze && snooze_left == 3'd0)) begin
                    state_d = S_ARMED;
                    left_d  = SNZ_MAX;
                end else if (snooze) begin
                    state_d   = S_SNOOZE;
                    snz_cnt_d = '0;
                    left_d    = snooze_left - 3'd1;
                end else if (ena) begin
                    ring_cnt_d = ring_cnt_inc;
                    if (ring_cnt_inc >= RING_LIM) begin
                        state_d = S_ARMED;
                        left_d  = SNZ_MAX;
                    end
                end
            end
            default: begin
                if (stop) begin
                    state_d = S_ARMED;
                    left_d  = SNZ_MAX;
                end else if (ena) begin
                    snz_cnt_d = snz_cnt_inc;
                    if (snz_cnt_inc >= SNZ_LIM) begin
                        state_d    = S_RINGING;
                        ring_cnt_d = '0;
                    end
                end
            end
        endcase

        // A valid new alarm time cancels the current alarm event.
        if (set_alarm && set_ok && (state == S_RINGING || state == S_SNOOZE)) begin
            state_d = S_ARMED;
            left_d  = SNZ_MAX;
        end

        if (!arm) state_d = S_IDLE;

`ifdef ALARM_BEEP_EN
        // Start high on entry, then toggle on each tick while ringing.
        if (state_d != S_RINGING) begin
            ring_d = 1'b0;
        end else if (state != S_RINGING) begin
            ring_d = 1'b1;
        end else if (ena) begin
            ring_d = ~ring;
        end else begin
            ring_d = ring;
        end
`else
        ring_d = (state_d == S_RINGING);
`endif
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            snooze_left <= SNZ_MAX;
            ring        <= 1'b0;
            set_err     <= 1'b0;
            alarm_hh    <= 8'h12;
            alarm_mm    <= 8'h00;
            alarm_pm    <= 1'b0;
        end else begin
            state       <= state_d;
            ring_cnt    <= ring_cnt_d;
            snz_cnt     <= snz_cnt_d;
            snooze_left <= left_d;
            ring        <= ring_d;
            set_err     <= set_alarm && !set_ok;
            if (set_alarm && set_ok) begin
                alarm_hh <= set_hh;
                alarm_mm <= set_mm;
                alarm_pm <= set_pm;
            end
        end
    end

endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: directed plus randomized bench for alarm_unit (default build,
// default parameters). A behavioural model tracks the alarm using remaining-
// time countdowns and is compared against every DUT output after each edge.
module tb_alarm_unit;

    localparam int SNOOZE_SEC = 300;
    localparam int RING_SEC   = 60;
    localparam int MAX_SNOOZE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] hh = 8'h12, mm = 8'h00, ss = 8'h00;
    logic       pm = 1'b0;
    logic       arm = 1'b0;
    logic       set_alarm = 1'b0;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00;
    logic       set_pm = 1'b0;
    logic       snooze = 1'b0, stop = 1'b0;
    logic [7:0] alarm_hh, alarm_mm;
    logic       alarm_pm, ring, set_err;
    logic [1:0] state;
    logic [2:0] snooze_left;

    int checks = 0;
    int failures = 0;

    // Model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing.
    int         m_mode = 0;
    int         m_left = MAX_SNOOZE;
    int         m_ring_rem = 0;
    int         m_snz_rem = 0;
    bit         m_ring = 0;
    bit         m_err = 0;
    logic [7:0] m_ah = 8'h12, m_am = 8'h00;
    logic       m_ap = 1'b0;

    alarm_unit #(.SNOOZE_SEC(SNOOZE_SEC), .RING_SEC(RING_SEC), .MAX_SNOOZE(MAX_SNOOZE)) dut (
        .clk(clk), .reset(reset), .ena(ena), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
        .arm(arm), .set_alarm(set_alarm), .set_hh(set_hh), .set_mm(set_mm),
        .set_pm(set_pm), .snooze(snooze), .stop(stop), .alarm_hh(alarm_hh),
        .alarm_mm(alarm_mm), .alarm_pm(alarm_pm), .ring(ring), .state(state),
        .snooze_left(snooze_left), .set_err(set_err)
    );

    always #5 clk = ~clk;

    function automatic bit bcd_in_range(input logic [7:0] v, input int lo, input int hi);
        int t, o;
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        return (t <= 9) && (o <= 9) && (t * 10 + o >= lo) && (t * 10 + o <= hi);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit ok, hit;
        int nxt;
        if (!reset) begin
            m_mode = 0; m_left = MAX_SNOOZE; m_ring_rem = 0; m_snz_rem = 0;
            m_ring = 0; m_err = 0; m_ah = 8'h12; m_am = 8'h00; m_ap = 1'b0;
        end else begin
            ok    = bcd_in_range(set_hh, 1, 12) && bcd_in_range(set_mm, 0, 59);
            m_err = set_alarm && !ok;
            hit   = ena && hh == m_ah && mm == m_am && pm == m_ap && ss == 8'h00;
            nxt   = m_mode;
            if (m_mode == 0) begin
                if (arm) nxt = 1;
            end else if (m_mode == 1) begin
                if (hit) begin nxt = 2; m_ring_rem = RING_SEC; end
            end else if (m_mode == 2) begin
                if (stop || (snooze && m_left == 0)) begin
                    nxt = 1; m_left = MAX_SNOOZE;
                end else if (snooze) begin
                    nxt = 3; m_left = m_left - 1; m_snz_rem = SNOOZE_SEC;
                end else if (ena) begin
                    m_ring_rem = m_ring_rem - 1;
                    if (m_ring_rem == 0) begin nxt = 1; m_left = MAX_SNOOZE; end
                end
            end else begin
                if (stop) begin
                    nxt = 1; m_left = MAX_SNOOZE;
                end else if (ena) begin
                    m_snz_rem = m_snz_rem - 1;
                    if (m_snz_rem == 0) begin nxt = 2; m_ring_rem = RING_SEC; end
                end
            end
            if (set_alarm && ok) begin
                if (m_mode >= 2) begin nxt = 1; m_left = MAX_SNOOZE; end
                m_ah = set_hh; m_am = set_mm; m_ap = set_pm;
            end
            if (!arm) nxt = 0;
            m_mode = nxt;
            m_ring = (nxt == 2);
        end
    endtask

    // One clock: update model, sample DUT after the edge, release pulses.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("state", 32'(state), 32'(m_mode));
        chk("ring", 32'(ring), 32'(m_ring));
        chk("snooze_left", 32'(snooze_left), 32'(m_left));
        chk("set_err", 32'(set_err), 32'(m_err));
        chk("alarm_hh", 32'(alarm_hh), 32'(m_ah));
        chk("alarm_mm", 32'(alarm_mm), 32'(m_am));
        chk("alarm_pm", 32'(alarm_pm), 32'(m_ap));
        ena = 1'b0; set_alarm = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic tick_and_gap();
        ena = 1'b1;
        step();
        step();
    endtask

    task automatic load_alarm(input logic [7:0] h, input logic [7:0] m, input logic p);
        set_hh = h; set_mm = m; set_pm = p; set_alarm = 1'b1;
        step();
    endtask

    // Drive the 07:30:00 AM tick, then move the clock off second zero.
    task automatic trigger_0730();
        hh = 8'h07; mm = 8'h30; ss = 8'h00; pm = 1'b0; ena = 1'b1;
        step();
        ss = 8'h01;
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_alarm_hh", 32'(alarm_hh), 32'h12);
        chk("rst_left", 32'(snooze_left), 32'd3);
        reset = 1'b1; arm = 1'b1;
        step();
        chk("armed", 32'(state), 32'h1);

        // Set and match
        load_alarm(8'h07, 8'h30, 1'b0);
        chk("set_hh", 32'(alarm_hh), 32'h07);
        hh = 8'h07; mm = 8'h29; ss = 8'h59; pm = 1'b0; ena = 1'b1;
        step();
        step();
        trigger_0730();
        chk("match_state", 32'(state), 32'h2);
        chk("match_ring", 32'(ring), 32'h1);
        stop = 1'b1;
        step();
        chk("stop_ring", 32'(ring), 32'h0);

        // AM/PM mismatch
        hh = 8'h07; mm = 8'h30; ss = 8'h00; pm = 1'b1; ena = 1'b1;
        step();
        chk("pm_mismatch_state", 32'(state), 32'h1);
        chk("pm_mismatch_ring", 32'(ring), 32'h0);

        // Snooze until exhausted
        trigger_0730();
        for (int k = 0; k < MAX_SNOOZE; k++) begin
            snooze = 1'b1;
            step();
            chk("snooze_state", 32'(state), 32'h3);
            chk("snooze_ring", 32'(ring), 32'h0);
            chk("snooze_cnt", 32'(snooze_left), 32'(MAX_SNOOZE - 1 - k));
            repeat (SNOOZE_SEC) tick_and_gap();
            chk("snooze_back", 32'(state), 32'h2);
        end
        snooze = 1'b1;
        step();
        chk("snooze_none", 32'(state), 32'h1);
        chk("snooze_reload", 32'(snooze_left), 32'd3);

        // Timeout
        trigger_0730();
        repeat (RING_SEC - 1) tick_and_gap();
        chk("pre_timeout", 32'(state), 32'h2);
        tick_and_gap();
        chk("timeout_state", 32'(state), 32'h1);
        chk("timeout_ring", 32'(ring), 32'h0);

        // Stop and snooze together
        trigger_0730();
        stop = 1'b1; snooze = 1'b1;
        step();
        chk("stop_snooze", 32'(state), 32'h1);

        // Bad sets
        load_alarm(8'h13, 8'h00, 1'b0);
        chk("bad_hh_err", 32'(set_err), 32'h1);
        chk("bad_hh_keep", 32'(alarm_hh), 32'h07);
        step();
        chk("err_pulse", 32'(set_err), 32'h0);
        load_alarm(8'h08, 8'h5A, 1'b0);
        chk("bad_mm_err", 32'(set_err), 32'h1);
        chk("bad_mm_keep", 32'(alarm_mm), 32'h30);

        // Valid set while ringing cancels the ring
        trigger_0730();
        load_alarm(8'h08, 8'h15, 1'b1);
        chk("set_ring_state", 32'(state), 32'h1);

        // Reset mid-ring
        hh = 8'h08; mm = 8'h15; ss = 8'h00; pm = 1'b1; ena = 1'b1;
        step();
        chk("ring_pm", 32'(ring), 32'h1);
        reset = 1'b0;
        step();
        chk("rst_ring", 32'(ring), 32'h0);
        chk("rst_alarm_mm", 32'(alarm_mm), 32'h00);
        reset = 1'b1;
        step();

        // Disarm during snooze
        load_alarm(8'h07, 8'h30, 1'b0);
        trigger_0730();
        snooze = 1'b1;
        step();
        arm = 1'b0;
        step();
        chk("disarm", 32'(state), 32'h0);
        arm = 1'b1;
        step();

        // Randomized traffic around the stored alarm time
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            arm   = ($urandom_range(0, 49) != 0);
            ena   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                hh = m_ah; mm = m_am; pm = m_ap; ss = 8'h00;
            end else begin
                hh = to_bcd($urandom_range(1, 12));
                mm = to_bcd($urandom_range(0, 59));
                ss = to_bcd($urandom_range(0, 2));
                pm = 1'($urandom_range(0, 1));
            end
            snooze    = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            set_alarm = ($urandom_range(0, 59) == 0);
            set_pm    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                set_hh = to_bcd($urandom_range(1, 12));
                set_mm = to_bcd($urandom_range(0, 59));
            end else begin
                set_hh = 8'($urandom_range(0, 255));
                set_mm = 8'($urandom_range(0, 255));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
